// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the audio stream controller.
//   - Avalon-MM word addresses of the register file
//   - bit positions inside the STATUS and CTRL registers
//   - frame_t: one interleaved frame at the default geometry (2 x 16-bit)
//   - ptr_w(): width of a pointer able to index n entries (at least 1 bit)
package audio_pkg;

  // Register map (word addresses)
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_DIV    = 3'd3;
  localparam logic [2:0] ADDR_WMARK  = 3'd4;

  // STATUS bit positions ([15:0] is the fill level)
  localparam int STAT_OVF = 16;
  localparam int STAT_UDF = 17;
  localparam int STAT_EN  = 18;
  localparam int STAT_IRQ = 19;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_ERR = 2;
  localparam int CTRL_CLR_IRQ = 3;
  localparam int CTRL_IRQ_EN  = 4;

  // Default frame geometry
  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_SAMPLE_W = 16;
  localparam int FRAME_W      = DEF_NUM_CH * DEF_SAMPLE_W;

  typedef logic [FRAME_W-1:0] frame_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: synchronous frame FIFO with fill level.
//   clk, reset      system clock, synchronous active-high reset
//   flush           empties the FIFO (pointers and level to 0)
//   push, wdata     enqueue one frame; accepted when not full, or when a pop
//                   happens in the same cycle
//   pop, rdata      dequeue the head frame; rdata shows the head combinationally
//   full, empty     occupancy flags
//   level           current number of stored frames
//   level_next      number of frames after this cycle's push/pop/flush
module audio_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign rdata = mem[rd_ptr_q];
  assign level = level_q;
  assign level_next = level_d;

  // When full, a simultaneous pop frees the slot the push lands in; the head
  // is read out combinationally before the write takes effect at the edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: Avalon-MM audio sample controller.
// Accepts interleaved PCM samples on DATA, assembles whole frames in a
// staging register, buffers them in a frame FIFO and releases one frame per
// programmable sample period.
//   clk, reset         system clock, synchronous active-high reset
//   address/chipselect/read/write/writedata   Avalon-MM slave, no waitrequest
//   readdata           registered read data (1-cycle latency)
//   sample_out         current frame, channel 0 in the LSBs
//   sample_valid       one-cycle pulse per sample period
//   irq                low-watermark interrupt
// Build option: define AUDIO_IRQ_EN to include the WMARK register, the
// irq_pending status bit and the irq output; without it irq is tied to 0.
// Valid/ready: the bus has no backpressure; every chipselect&write is
// consumed in its cycle and every chipselect&read answers in the next cycle.
module audio_stream_ctrl
  import audio_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int DEPTH       = 64,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1041
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   address,
  input  logic                         chipselect,
  input  logic                         read,
  input  logic                         write,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [NUM_CH*SAMPLE_W-1:0]   sample_out,
  output logic                         sample_valid,
  output logic                         irq
);

  localparam int FW = NUM_CH * SAMPLE_W;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = ptr_w(NUM_CH);

  // Bus decode
  logic wr_en, rd_en, wr_data, wr_ctrl, wr_div, flush;
  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign wr_data = wr_en && (address == ADDR_DATA);
  assign wr_ctrl = wr_en && (address == ADDR_CTRL);
  assign wr_div  = wr_en && (address == ADDR_DIV);
  assign flush   = wr_ctrl & writedata[CTRL_FLUSH];

  // State
  logic [FW-1:0]    stage_q, stage_d;
  logic [CW-1:0]    ch_ptr_q, ch_ptr_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [FW-1:0]    sample_out_q, sample_out_d;
  logic             sample_valid_q, sample_valid_d;
  logic [31:0]      readdata_q, readdata_d;

  // Datapath
  logic          push, pop, tick;
  logic [FW-1:0] push_frame, fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level, fifo_level_nxt;

  logic unused_wd;
  assign unused_wd = ^writedata;

  // Staging: samples land in channel order; the last channel completes the
  // frame and pushes it together with the incoming sample.
  always_comb begin
    stage_d  = stage_q;
    ch_ptr_d = ch_ptr_q;
    push     = 1'b0;
    if (flush) begin
      stage_d  = '0;
      ch_ptr_d = '0;
    end else if (wr_data) begin
      stage_d[ch_ptr_q*SAMPLE_W +: SAMPLE_W] = writedata[SAMPLE_W-1:0];
      if (int'(ch_ptr_q) == NUM_CH - 1) begin
        ch_ptr_d = '0;
        push     = 1'b1;
      end else begin
        ch_ptr_d = ch_ptr_q + 1'b1;
      end
    end
    push_frame = stage_d;
  end

  // Rate generator: holds at DIV while disabled, ticks on reaching 0,
  // so the period is DIV+1 cycles. A DIV write reloads the count.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (!en_q) begin
      cnt_d = div_q;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    if (wr_div) cnt_d = writedata[DIV_W-1:0];
  end

  assign pop = tick & ~fifo_empty;

  audio_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .wdata      (push_frame),
    .pop        (pop),
    .rdata      (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level),
    .level_next (fifo_level_nxt)
  );

  // Control, sticky flags and output registers
  always_comb begin
    en_d  = en_q;
    div_d = div_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (wr_ctrl) en_d = writedata[CTRL_EN];
    if (wr_div)  div_d = writedata[DIV_W-1:0];
    if (wr_ctrl && writedata[CTRL_CLR_ERR]) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    // A new error in the clearing cycle wins over the clear.
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (tick && fifo_empty)        udf_d = 1'b1;

    sample_valid_d = tick;
    sample_out_d   = sample_out_q;
    if (tick) sample_out_d = pop ? fifo_rdata : '0;
  end

`ifdef AUDIO_IRQ_EN
  logic [LW-1:0] wmark_q, wmark_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_pend_q, irq_pend_d;

  // irq_pending fires when a pop carries the level from at/above the
  // watermark to below it.
  always_comb begin
    wmark_d    = wmark_q;
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (wr_en && (address == ADDR_WMARK)) wmark_d = writedata[LW-1:0];
    if (wr_ctrl) irq_en_d = writedata[CTRL_IRQ_EN];
    if (wr_ctrl && writedata[CTRL_CLR_IRQ]) irq_pend_d = 1'b0;
    if (pop && (fifo_level >= wmark_q) && (fifo_level_nxt < wmark_q)) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wmark_q    <= LW'(DEPTH / 4);
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      wmark_q    <= wmark_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq = irq_pend_q & irq_en_q;
`else
  logic unused_lvl_nxt;
  assign unused_lvl_nxt = ^fifo_level_nxt;
  assign irq = 1'b0;
`endif

  // Read mux, registered for 1-cycle latency; holds between reads.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      case (address)
        ADDR_STATUS: begin
          readdata_d[15:0]     = 16'(fifo_level);
          readdata_d[STAT_OVF] = ovf_q;
          readdata_d[STAT_UDF] = udf_q;
          readdata_d[STAT_EN]  = en_q;
`ifdef AUDIO_IRQ_EN
          readdata_d[STAT_IRQ] = irq_pend_q;
`endif
        end
        ADDR_CTRL: begin
          readdata_d[CTRL_EN] = en_q;
`ifdef AUDIO_IRQ_EN
          readdata_d[CTRL_IRQ_EN] = irq_en_q;
`endif
        end
        ADDR_DIV: readdata_d[DIV_W-1:0] = div_q;
`ifdef AUDIO_IRQ_EN
        ADDR_WMARK: readdata_d[LW-1:0] = wmark_q;
`endif
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q        <= '0;
      ch_ptr_q       <= '0;
      en_q           <= 1'b0;
      div_q          <= DIV_W'(DEFAULT_DIV);
      cnt_q          <= DIV_W'(DEFAULT_DIV);
      ovf_q          <= 1'b0;
      udf_q          <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      readdata_q     <= '0;
    end else begin
      stage_q        <= stage_d;
      ch_ptr_q       <= ch_ptr_d;
      en_q           <= en_d;
      div_q          <= div_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      udf_q          <= udf_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: doc/audio_stream_ctrl.md
# audio_stream_ctrl

Parametrised successor to the current audio controller: an Avalon-MM slave that accepts interleaved multi-channel PCM samples from the HPS, buffers whole frames in an on-chip FIFO, and releases one frame per programmable sample period to the codec-side datapath. It sits inside soc_system on the lightweight HPS-to-FPGA bridge and adds frame buffering, a rate generator, flush, and overflow/underrun accounting.

## Interface
- NUM_CH, 2, channels per frame (1..8)
- SAMPLE_W, 16, bits per sample (8..32)
- DEPTH, 64, FIFO depth in frames, power of two
- DIV_W, 16, width of the sample-period divider
- DEFAULT_DIV, 1041, divider reset value (50 MHz / 1042 ≈ 48 kHz)
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- address  in  3  word address
- chipselect  in  1  slave select
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- sample_out  out  NUM_CH*SAMPLE_W  current frame, channel 0 in LSBs
- sample_valid  out  1  one-cycle pulse per sample period
- irq  out  1  low-watermark interrupt (AUDIO_IRQ_EN only; else tied 0)

## Operation
- Registers (word address): 0 DATA (W), 1 STATUS (R), 2 CTRL (RW), 3 DIV (RW), 4 WMARK (RW, AUDIO_IRQ_EN only). Unmapped reads return 0.
- DATA write: writedata[SAMPLE_W-1:0] goes into staging[ch_ptr]; ch_ptr increments. When it reaches NUM_CH, ch_ptr returns to 0 and the assembled frame is pushed.
- Push when FIFO full and no pop in the same cycle: the frame is dropped and STATUS.ovf is set. Push and pop in the same cycle are both honoured, including when full.
- STATUS: [15:0] fill level in frames, [16] ovf sticky, [17] udf sticky, [18] enable, [19] irq_pending.
- CTRL: [0] enable. Writing 1 to [1] flushes (self-clearing); writing 1 to [2] clears ovf/udf; writing 1 to [3] clears irq_pending.
- Flush resets the FIFO pointers, ch_ptr and staging. A DATA write in the flush cycle is discarded.
- Rate generator: a down-counter loads DIV and ticks when it reaches 0, giving a period of DIV+1 cycles. While enable=0 the counter holds at DIV and no ticks occur. A write to DIV reloads the counter.
- On tick with FIFO non-empty: pop one frame, drive sample_out, pulse sample_valid.
- On tick with FIFO empty: sample_out becomes 0, sample_valid still pulses, and udf is set.
- Reset values:
  - readdata = 0, sample_out = 0, sample_valid = 0, irq = 0.
  - FIFO empty, ch_ptr = 0, CTRL = 0, sticky bits = 0.
  - DIV = DEFAULT_DIV, WMARK = DEPTH/4.

## Timing
- Read latency is 1 cycle: readdata is valid in the cycle after chipselect&read. There is no waitrequest.
- A DATA write is visible in STATUS.level on the next cycle; a read in that next cycle returns the updated level.
- Tick to sample_out/sample_valid is 1 cycle, registered.
- With enable set at cycle t, the first sample_valid occurs at t+DIV+2.
- DIV=0 gives a tick every cycle while enabled.
- Reset mid-frame discards the partial staging frame and any in-flight FIFO content.

## Configuration
- AUDIO_IRQ_EN defined:
  - WMARK register present.
  - irq_pending is set on the cycle level drops below WMARK after a pop.
  - irq = irq_pending & CTRL[4] (irq enable).
- AUDIO_IRQ_EN undefined:
  - Address 4 reads 0; writes to it are ignored.
  - irq is tied to 0.
  - STATUS[19] reads 0; CTRL[3] and CTRL[4] are ignored.

## Structure
- Package audio_pkg holds:
  - register address constants (ADDR_DATA..ADDR_WMARK);
  - STATUS/CTRL bit positions;
  - a frame typedef parameterised via localparam width NUM_CH*SAMPLE_W.
- Sub-module audio_frame_fifo: synchronous FIFO of DEPTH×(NUM_CH*SAMPLE_W) with level output, push/pop/flush and simultaneous push+pop support. The top level holds the register file, staging, rate generator and output registers.

## Test plan
- Reset, then read DIV and STATUS -> 1041 and 0. Keep enable=0 for 2000 cycles -> no sample_valid.
- NUM_CH=2: write 0x1111, 0x2222; set DIV=9 and enable -> sample_valid with sample_out=0x22221111, then the next tick underruns -> sample_out=0, udf=1.
- Write 64 frames, then a 65th frame with enable=0 -> level=64, ovf=1, and the 65th frame is never output.
- Full FIFO with enable=1, DIV=0, and a frame committed in the same cycle as a tick pop -> level stays 64, ovf remains 0.
- Write one sample (half frame), then flush, then write 0xAAAA, 0xBBBB -> output frame 0xBBBBAAAA, level reaches 1 then 0.
- AUDIO_IRQ_EN with WMARK=4: fill 5 frames, CTRL=0x11, DIV=3 -> irq rises 1 cycle after the pop taking level to 3; CTRL[3] write clears it.
